csr_access_unit: RTL and testbench

Execute-stage initiator for the Zicsr instructions (CSRRW/RS/RC and their immediate forms). It accepts one decoded CSR instruction and runs a fixed read/modify/write sequence against the CSR file's read/write port. It returns the old CSR value for rd, or an illegal-instruction exception, over a valid/ready response interface. It sits between decode and the CSR file, and is the sole driver of the CSR file's access params.

---
 rtl/csr_access_unit.sv | 167 ++++++++++++++++
 tb/tb_csr_access_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Execute-stage initiator for Zicsr instructions (CSRRW/RS/RC and the
//   immediate forms). Accepts one decoded instruction, performs a fixed
//   READ -> WRITE -> RESP sequence on the CSR file port, and returns the old
//   CSR value (or an illegal-instruction exception) on a valid/ready response.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   req_*               : decoded CSR instruction, valid/ready handshake
//   priv_mode           : current privilege level (00 U, 01 S, 11 M)
//   csr_*               : CSR file read/write port (combinational read data)
//   resp_*              : result for rd / exception, valid/ready handshake
module csr_access_unit #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [4:0]            req_rs1_idx,
  input  logic [XLEN-1:0]       req_rs1_value,
  input  logic [4:0]            req_rd_idx,
  input  logic [1:0]            priv_mode,
  output logic                  csr_read_enable,
  output logic                  csr_write_enable,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]       csr_write_data,
  input  logic [XLEN-1:0]       csr_read_value,
  input  logic                  csr_illegal,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_rd_write,
  output logic [4:0]            resp_rd_idx,
  output logic [XLEN-1:0]       resp_rd_value,
  output logic                  resp_exception
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_t                  state, state_next;
  logic [1:0]              op_q;
  logic [CSR_ADDR_W-1:0]   addr_q;
  logic [4:0]              rd_q;
  logic [XLEN-1:0]         src_q;
  logic [XLEN-1:0]         old_q;
  logic                    wr_req_q;
  logic                    exc_q;

  logic                    accept;
  logic                    wr_req_in;
  logic                    exc_in;
  logic                    rd_issue;
  logic                    wr_issue;
  logic [XLEN-1:0]         wdata;

  assign accept = req_valid && (state == IDLE);

  // Write requirement keys off the rs1 index / uimm field, not the value.
  assign wr_req_in = (req_funct3[1:0] == OP_RW) || (req_rs1_idx != 5'd0);

  // Decode-time exception sources; csr_illegal is folded in later.
  assign exc_in = (req_funct3[1:0] == 2'b00) ||
                  (req_addr[9:8] > priv_mode) ||
                  ((req_addr[11:10] == 2'b11) && wr_req_in);

  assign rd_issue = (state == READ) && !((op_q == OP_RW) && (rd_q == 5'd0));
  assign wr_issue = (state == WRITE) && wr_req_q && !exc_q;

  always_comb begin
    wdata = '0;
    case (op_q)
      OP_RW:   wdata = src_q;
      OP_RS:   wdata = old_q | src_q;
      OP_RC:   wdata = old_q & ~src_q;
      default: wdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      rd_q     <= '0;
      src_q    <= '0;
      old_q    <= '0;
      wr_req_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= req_funct3[1:0];
            addr_q   <= req_addr;
            rd_q     <= req_rd_idx;
            src_q    <= req_funct3[2] ? XLEN'(req_rs1_idx) : req_rs1_value;
            wr_req_q <= wr_req_in;
            exc_q    <= exc_in;
          end
        end
        READ: begin
          if (rd_issue) begin
            old_q <= csr_read_value;
            if (csr_illegal) exc_q <= 1'b1;
          end else begin
            old_q <= '0;
          end
        end
        WRITE: begin
          if (wr_issue && csr_illegal) exc_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    csr_read_enable  = 1'b0;
    csr_write_enable = 1'b0;
    csr_addr         = '0;
    csr_write_data   = '0;
    resp_valid       = 1'b0;
    resp_rd_write    = 1'b0;
    resp_rd_idx      = '0;
    resp_rd_value    = '0;
    resp_exception   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = READ;
      end
      READ: begin
        csr_addr        = addr_q;
        csr_read_enable = rd_issue;
        state_next      = WRITE;
      end
      WRITE: begin
        if (wr_issue) begin
          csr_write_enable = 1'b1;
          csr_addr         = addr_q;
          csr_write_data   = wdata;
        end
        state_next = RESP;
      end
      RESP: begin
        resp_valid     = 1'b1;
        resp_rd_idx    = rd_q;
        resp_exception = exc_q;
        resp_rd_write  = !exc_q && (rd_q != 5'd0);
        resp_rd_value  = exc_q ? '0 : old_q;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_value;
  logic [4:0]  req_rd_idx;
  logic [1:0]  priv_mode;
  logic        csr_read_enable;
  logic        csr_write_enable;
  logic [11:0] csr_addr;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_value;
  logic        csr_illegal;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_rd_write;
  logic [4:0]  resp_rd_idx;
  logic [31:0] resp_rd_value;
  logic        resp_exception;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  csr_access_unit #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_rs1_idx(req_rs1_idx), .req_rs1_value(req_rs1_value),
    .req_rd_idx(req_rd_idx), .priv_mode(priv_mode),
    .csr_read_enable(csr_read_enable), .csr_write_enable(csr_write_enable),
    .csr_addr(csr_addr), .csr_write_data(csr_write_data),
    .csr_read_value(csr_read_value), .csr_illegal(csr_illegal),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd_write(resp_rd_write), .resp_rd_idx(resp_rd_idx),
    .resp_rd_value(resp_rd_value), .resp_exception(resp_exception)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [31:0] rs1v;
    logic [4:0]  rd;
    logic [1:0]  priv;
    logic [31:0] rdata;
    logic        ill_rd;
    logic        ill_wr;
    logic        e_rden;
    logic        e_wren;
    logic [31:0] e_wdata;
    logic        e_rdw;
    logic [31:0] e_rdv;
    logic        e_exc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
    input logic [31:0] rs1v, input logic [4:0] rd, input logic [1:0] priv,
    input logic [31:0] rdata, input logic ill_rd, input logic ill_wr,
    input logic e_rden, input logic e_wren, input logic [31:0] e_wdata,
    input logic e_rdw, input logic [31:0] e_rdv, input logic e_exc);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.rs1 = rs1; v.rs1v = rs1v; v.rd = rd;
    v.priv = priv; v.rdata = rdata; v.ill_rd = ill_rd; v.ill_wr = ill_wr;
    v.e_rden = e_rden; v.e_wren = e_wren; v.e_wdata = e_wdata;
    v.e_rdw = e_rdw; v.e_rdv = e_rdv; v.e_exc = e_exc;
    return v;
  endfunction

  // Drives one instruction and checks every cycle of its fixed 4-cycle flow.
  // stall: cycles resp_ready is held low in RESP; hold_valid keeps req_valid
  // asserted while the unit is busy (must be ignored).
  task automatic run_vec(input vec_t v, input int idx, input int stall, input bit hold_valid);
    @(negedge clock);
    req_funct3 = v.f3; req_addr = v.addr; req_rs1_idx = v.rs1;
    req_rs1_value = v.rs1v; req_rd_idx = v.rd; priv_mode = v.priv;
    csr_read_value = v.rdata; csr_illegal = 1'b0; req_valid = 1'b1;
    chk($sformatf("v%0d req_ready_idle", idx), req_ready, 1);
    @(negedge clock);                       // READ
    if (!hold_valid) req_valid = 1'b0;
    chk($sformatf("v%0d read_enable", idx), csr_read_enable, v.e_rden);
    chk($sformatf("v%0d write_enable_c1", idx), csr_write_enable, 0);
    chk($sformatf("v%0d req_ready_c1", idx), req_ready, 0);
    if (v.e_rden) chk($sformatf("v%0d read_addr", idx), csr_addr, v.addr);
    csr_illegal = v.ill_rd;
    @(negedge clock);                       // WRITE
    chk($sformatf("v%0d read_enable_c2", idx), csr_read_enable, 0);
    chk($sformatf("v%0d write_enable", idx), csr_write_enable, v.e_wren);
    chk($sformatf("v%0d write_data", idx), csr_write_data, v.e_wdata);
    chk($sformatf("v%0d write_addr", idx), csr_addr, v.e_wren ? v.addr : 12'h000);
    chk($sformatf("v%0d resp_valid_c2", idx), resp_valid, 0);
    csr_illegal = v.ill_wr;
    @(negedge clock);                       // RESP
    csr_illegal = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      chk($sformatf("v%0d resp_valid c%0d", idx, 3 + s), resp_valid, 1);
      chk($sformatf("v%0d rd_write c%0d", idx, 3 + s), resp_rd_write, v.e_rdw);
      chk($sformatf("v%0d rd_idx c%0d", idx, 3 + s), resp_rd_idx, v.rd);
      chk($sformatf("v%0d rd_value c%0d", idx, 3 + s), resp_rd_value, v.e_rdv);
      chk($sformatf("v%0d exception c%0d", idx, 3 + s), resp_exception, v.e_exc);
      chk($sformatf("v%0d req_ready c%0d", idx, 3 + s), req_ready, 0);
      chk($sformatf("v%0d wr_en c%0d", idx, 3 + s), csr_write_enable, 0);
      if (s < stall) @(negedge clock);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clock);
    resp_ready = 1'b0;
    chk($sformatf("v%0d resp_valid_after", idx), resp_valid, 0);
    chk($sformatf("v%0d req_ready_after", idx), req_ready, 1);
  endtask

  initial begin
    //             f3    addr    rs1    rs1v          rd     priv   rdata        ird  iwr  rden wren wdata         rdw  rdv           exc
    vecs[0]  = mk(3'b010, 12'hC00, 5'd0,  32'h0,        5'd5,  2'b11, 32'h0000_1234, 0, 0, 1, 0, 32'h0,         1, 32'h0000_1234, 0);
    vecs[1]  = mk(3'b001, 12'h340, 5'd7,  32'hDEAD_BEEF, 5'd0, 2'b11, 32'h0000_0055, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0);
    vecs[2]  = mk(3'b111, 12'h300, 5'h0A, 32'h1234_5678, 5'd3, 2'b11, 32'h0000_00FF, 0, 0, 1, 1, 32'h0000_00F5, 1, 32'h0000_00FF, 0);
    vecs[3]  = mk(3'b001, 12'hC00, 5'd2,  32'h0000_0001, 5'd1, 2'b11, 32'h0000_0099, 0, 0, 1, 0, 32'h0,         0, 32'h0,         1);
    vecs[4]  = mk(3'b010, 12'h300, 5'd4,  32'h0000_0008, 5'd1, 2'b00, 32'h0000_0011, 0, 0, 1, 0, 32'h0,         0, 32'h0,         1);
    vecs[5]  = mk(3'b001, 12'h7FF, 5'd3,  32'h0000_0005, 5'd2, 2'b11, 32'h0000_0033, 1, 0, 1, 0, 32'h0,         0, 32'h0,         1);
    vecs[6]  = mk(3'b110, 12'h305, 5'h11, 32'hFFFF_FFFF, 5'd4, 2'b11, 32'h0000_0100, 0, 0, 1, 1, 32'h0000_0111, 1, 32'h0000_0100, 0);
    vecs[7]  = mk(3'b101, 12'h340, 5'h1F, 32'h0,        5'd6,  2'b11, 32'h0000_ABCD, 0, 0, 1, 1, 32'h0000_001F, 1, 32'h0000_ABCD, 0);
    vecs[8]  = mk(3'b000, 12'h300, 5'd2,  32'h0000_0003, 5'd1, 2'b11, 32'h0000_0007, 0, 0, 1, 0, 32'h0,         0, 32'h0,         1);
    vecs[9]  = mk(3'b001, 12'h341, 5'd3,  32'h0000_0077, 5'd2, 2'b11, 32'h0000_0044, 0, 1, 1, 1, 32'h0000_0077, 0, 32'h0,         1);
    vecs[10] = mk(3'b011, 12'h300, 5'd0,  32'h0000_FFFF, 5'd7, 2'b11, 32'h0000_0F0F, 0, 0, 1, 0, 32'h0,         1, 32'h0000_0F0F, 0);
    vecs[11] = mk(3'b010, 12'h100, 5'd9,  32'h0000_0002, 5'd8, 2'b01, 32'h0000_0020, 0, 0, 1, 1, 32'h0000_0022, 1, 32'h0000_0020, 0);
    vecs[12] = mk(3'b010, 12'h300, 5'd0,  32'h0,        5'd0,  2'b11, 32'h0000_0042, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0042, 0);

    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_idx = '0; req_rs1_value = '0; req_rd_idx = '0; priv_mode = 2'b11;
    csr_read_value = '0; csr_illegal = 1'b0; resp_ready = 1'b0;

    repeat (2) @(negedge clock);
    chk("reset req_ready", req_ready, 1);
    chk("reset read_enable", csr_read_enable, 0);
    chk("reset write_enable", csr_write_enable, 0);
    chk("reset csr_addr", csr_addr, 0);
    chk("reset write_data", csr_write_data, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset rd_value", resp_rd_value, 0);
    chk("reset exception", resp_exception, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i, 0, 1'b0);

    // Response stall with req_valid held: outputs must stay frozen.
    run_vec(vecs[2], 100, 5, 1'b1);

    // Asynchronous reset in the WRITE cycle of a writing instruction.
    @(negedge clock);
    req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_idx = 5'd7;
    req_rs1_value = 32'hCAFE_F00D; req_rd_idx = 5'd1; priv_mode = 2'b11;
    csr_read_value = 32'h1; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("pre-reset write_enable", csr_write_enable, 1);
    #1 reset = 1'b1;
    #1;
    chk("async reset write_enable", csr_write_enable, 0);
    chk("async reset write_data", csr_write_data, 0);
    chk("async reset csr_addr", csr_addr, 0);
    chk("async reset req_ready", req_ready, 1);
    chk("async reset resp_valid", resp_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("post-reset idle wr_en c%0d", c), csr_write_enable, 0);
      chk($sformatf("post-reset idle resp_valid c%0d", c), resp_valid, 0);
    end
    run_vec(vecs[6], 200, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
